// File: rtl/pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and parity to a router.
// Optional macro PKT_TX_PARITY_CORRUPT_EN adds corrupt_parity to invert the parity byte.
module pkt_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
`ifdef PKT_TX_PARITY_CORRUPT_EN
  input  logic       corrupt_parity,
`endif
  input  logic [7:0] pld_data,
  input  logic       pld_valid,
  output logic       pld_ready,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_busy,
  output logic       done,
  output logic       reject,
  output logic       err_seen
);

  typedef enum logic [2:0] {IDLE, LOAD, HDR, PLD, PAR, CHK} state_t;

  state_t     state_q, state_d;
  logic [1:0] dest_q, dest_d;
  logic [5:0] len_q, len_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] par_q, par_d;
  logic [1:0] chk_q, chk_d;
  logic       inv_q, inv_d;
  logic       done_q, done_d;
  logic       reject_q, reject_d;
  logic       err_seen_q, err_seen_d;
  logic       buf_we;
  logic [7:0] buf_q [64];

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    idx_d      = idx_q;
    par_d      = par_q;
    chk_d      = chk_q;
    inv_d      = inv_q;
    done_d     = 1'b0;
    reject_d   = 1'b0;
    err_seen_d = err_seen_q;
    buf_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (dest != 2'd3 && len != 6'd0) begin
            dest_d     = dest;
            len_d      = len;
            idx_d      = 6'd0;
            par_d      = {len, dest};
            err_seen_d = 1'b0;
`ifdef PKT_TX_PARITY_CORRUPT_EN
            inv_d      = corrupt_parity;
`else
            inv_d      = 1'b0;
`endif
            state_d    = LOAD;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (pld_valid) begin
          buf_we = 1'b1;
          par_d  = par_q ^ pld_data;
          if (idx_q == len_q - 6'd1) begin
            idx_d   = 6'd0;
            state_d = HDR;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      HDR: begin
        if (!busy) state_d = PLD;
      end
      PLD: begin
        if (!busy) begin
          if (idx_q == len_q - 6'd1) begin
            idx_d   = 6'd0;
            state_d = PAR;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      PAR: begin
        if (!busy) begin
          chk_d   = 2'd0;
          state_d = CHK;
        end
      end
      CHK: begin
        if (err) err_seen_d = 1'b1;
        // Three fixed cycles for the router to report a parity error
        if (chk_q == 2'd2) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          chk_d = chk_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dest_q     <= 2'd0;
      len_q      <= 6'd0;
      idx_q      <= 6'd0;
      par_q      <= 8'h00;
      chk_q      <= 2'd0;
      inv_q      <= 1'b0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      chk_q      <= chk_d;
      inv_q      <= inv_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
      err_seen_q <= err_seen_d;
    end
  end

  // Payload store needs no reset; contents after an abort are never read
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q] <= pld_data;
  end

  // Router-facing outputs decode registered state only
  always_comb begin
    pkt_valid = 1'b0;
    data_out  = 8'h00;
    case (state_q)
      HDR: begin
        pkt_valid = 1'b1;
        data_out  = {len_q, dest_q};
      end
      PLD: begin
        pkt_valid = 1'b1;
        data_out  = buf_q[idx_q];
      end
      PAR:     data_out = par_q ^ {8{inv_q}};
      default: data_out = 8'h00;
    endcase
  end

  assign pld_ready = (state_q == LOAD);
  assign tx_busy   = (state_q != IDLE);
  assign done      = done_q;
  assign reject    = reject_q;
  assign err_seen  = err_seen_q;

endmodule

// File: tb/tb_pkt_tx.sv
// Scoreboard bench for pkt_tx: stimulus pushes expected router bytes and pulses, a monitor pops and compares.
module tb_pkt_tx;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest = 2'd0;
  logic [5:0] len = 6'd0;
  logic [7:0] pld_data = 8'h00;
  logic       pld_valid = 1'b0;
  logic       busy = 1'b0;
  logic       err = 1'b0;
`ifdef PKT_TX_PARITY_CORRUPT_EN
  logic       corrupt_parity = 1'b0;
`endif
  logic       pld_ready, pkt_valid, tx_busy, done, reject, err_seen;
  logic [7:0] data_out;

  pkt_tx dut (
    .clk(clk), .reset(reset), .start(start), .dest(dest), .len(len),
`ifdef PKT_TX_PARITY_CORRUPT_EN
    .corrupt_parity(corrupt_parity),
`endif
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .busy(busy), .err(err), .pkt_valid(pkt_valid), .data_out(data_out),
    .tx_busy(tx_busy), .done(done), .reject(reject), .err_seen(err_seen)
  );

  always #5 clk = ~clk;

  // kind: 0 packet byte, 1 parity byte, 2 done (data = err_seen), 3 reject
  typedef struct { int kind; logic [7:0] data; } exp_t;
  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] pl [64];
  logic       par_arm = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input int l, input logic [7:0] par, input logic errf);
    push(0, hdr);
    for (int i = 0; i < l; i++) push(0, pl[i]);
    push(1, par);
    push(2, {7'b0, errf});
  endtask

  task automatic mon(input int k, input logic [7:0] d);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_output: got kind %0d data %0h expected nothing at %0t", k, d, $time);
    end else begin
      e = q.pop_front();
      chk("mon_kind", k, e.kind);
      chk("mon_data", {24'b0, d}, {24'b0, e.data});
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      par_arm = 1'b0;
    end else begin
      if (pkt_valid) begin
        par_arm = 1'b1;
        if (!busy) mon(0, data_out);
      end else if (par_arm && tx_busy && !busy) begin
        mon(1, data_out);
        par_arm = 1'b0;
      end
      if (done)   mon(2, {7'b0, err_seen});
      if (reject) mon(3, 8'h00);
    end
  end

  task automatic load_pkt(input logic [1:0] d, input logic [5:0] l, input logic [7:0] hdr);
    int rdy = 0;
    start = 1'b1;
    dest  = d;
    len   = l;
    @(posedge clk); #1;
    chk("errseen_cleared", {31'b0, err_seen}, 0);
    chk("load_ready", {31'b0, pld_ready}, 1);
    // stray invalid request while busy must be ignored
    start = 1'b1;
    dest  = 2'd3;
    len   = 6'd0;
    for (int i = 0; i < int'(l); i++) begin
      if (l > 6'd10 && i == 5) begin
        pld_valid = 1'b0;
        @(negedge clk); rdy += int'(pld_ready);
        @(posedge clk); #1;
      end
      pld_data  = pl[i];
      pld_valid = 1'b1;
      @(negedge clk); rdy += int'(pld_ready);
      @(posedge clk); #1;
    end
    pld_valid = 1'b0;
    start     = 1'b0;
    chk("ready_cycles", rdy, int'(l) + ((l > 6'd10) ? 1 : 0));
    chk("hdr_latency", {22'b0, pld_ready, pkt_valid, data_out}, {22'b0, 1'b0, 1'b1, hdr});
  endtask

  task automatic run_rest(input int l, input logic [7:0] hdr, input int hdr_busy, input int err_cyc);
    int hold = 0;
    bit got = 1'b0;
    if (hdr_busy > 0) begin
      busy = 1'b1;
      repeat (hdr_busy) begin
        @(negedge clk); if (pkt_valid && data_out == hdr) hold++;
        @(posedge clk); #1;
      end
      busy = 1'b0;
      @(negedge clk); if (pkt_valid && data_out == hdr) hold++;
      chk("hdr_hold", hold, hdr_busy + 1);
    end
    err = (err_cyc == 0);
    for (int n = 1; n <= l + 20 && !got; n++) begin
      @(posedge clk); #1;
      err = (err_cyc != 0) && (n == l + 1 + err_cyc);
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk("done_latency", n, l + 5);
      end
    end
    err = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    chk("err_seen_after", {31'b0, err_seen}, (err_cyc != 0) ? 1 : 0);
    chk("idle_after", {31'b0, tx_busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b1;
    #3;
    chk("reset_outputs", {17'b0, pkt_valid, data_out, pld_ready, tx_busy, done, reject, err_seen},
        32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // dest=1 len=3, no backpressure
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    push_pkt(8'h0D, 3, 8'h0D, 1'b0);
    load_pkt(2'd1, 6'd3, 8'h0D);
    run_rest(3, 8'h0D, 0, 0);

    // same packet, busy for 4 cycles in HDR
    push_pkt(8'h0D, 3, 8'h0D, 1'b0);
    load_pkt(2'd1, 6'd3, 8'h0D);
    run_rest(3, 8'h0D, 4, 0);

    // invalid requests
    push(3, 8'h00);
    start = 1'b1; dest = 2'd3; len = 6'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rej_dest_busy", {30'b0, tx_busy, pld_ready}, 0);
    @(posedge clk); #1;
    chk("rej_dest_busy2", {30'b0, tx_busy, pld_ready}, 0);
    push(3, 8'h00);
    start = 1'b1; dest = 2'd0; len = 6'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rej_len_busy", {30'b0, tx_busy, pld_ready}, 0);
    @(posedge clk); #1;

    // maximum length packet
    for (int i = 0; i < 63; i++) pl[i] = 8'(i);
    push_pkt(8'hFE, 63, 8'hC1, 1'b0);
    load_pkt(2'd2, 6'd63, 8'hFE);
    run_rest(63, 8'hFE, 0, 0);

    // router error in 2nd CHK cycle
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    push_pkt(8'h0D, 3, 8'h0D, 1'b1);
    load_pkt(2'd1, 6'd3, 8'h0D);
    run_rest(3, 8'h0D, 0, 2);

    // next accepted start clears err_seen; single byte packet
    pl[0] = 8'hA5;
    push_pkt(8'h04, 1, 8'hA1, 1'b0);
    load_pkt(2'd0, 6'd1, 8'h04);
    run_rest(1, 8'h04, 0, 0);

    // reset during second payload byte
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    push_pkt(8'h0D, 3, 8'h0D, 1'b0);
    load_pkt(2'd1, 6'd3, 8'h0D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("second_pld_byte", {23'b0, pkt_valid, data_out}, {23'b0, 1'b1, 8'h22});
    reset = 1'b1;
    #1;
    q.delete();
    chk("abort_outputs", {20'b0, pkt_valid, tx_busy, pld_ready, done, data_out}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    push_pkt(8'h0A, 2, 8'h93, 1'b0);
    load_pkt(2'd2, 6'd2, 8'h0A);
    run_rest(2, 8'h0A, 0, 0);

`ifdef PKT_TX_PARITY_CORRUPT_EN
    corrupt_parity = 1'b1;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    push_pkt(8'h0D, 3, 8'hF2, 1'b0);
    load_pkt(2'd1, 6'd3, 8'h0D);
    corrupt_parity = 1'b0;
    run_rest(3, 8'h0D, 0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_tx.md
PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 Timing: one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  packet request, sampled in IDLE only.
REQ-005 dest  in  2  destination port 0..2; 3 is invalid.
REQ-006 len  in  6  payload length 1..63; 0 is invalid.
REQ-007 pld_data  in  8  payload byte.
REQ-008 pld_valid  in  1  pld_data valid.
REQ-009 pld_ready  out  1  block accepts pld_data.
REQ-010 busy  in  1  router busy; holds the current byte.
REQ-011 err  in  1  router parity-error flag.
REQ-012 pkt_valid  out  1  packet-valid to router.
REQ-013 data_out  out  8  packet byte to router.
REQ-014 tx_busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at packet completion.
REQ-016 reject  out  1  one-cycle pulse on invalid request.
REQ-017 err_seen  out  1  sticky flag: router reported a parity error for the last packet.

Function
REQ-018 States: IDLE, LOAD, HDR, PLD, PAR, CHK. pkt_valid and data_out are decodes of registered state and buffer only, with no combinational path from any input.
REQ-019 IDLE: start=1 with dest<=2 and len>=1 → latch dest/len, clear err_seen, go to LOAD next edge.
REQ-020 IDLE: start=1 with dest=3 or len=0 → reject=1 for the next cycle, remain IDLE.
REQ-021 start is ignored outside IDLE.
REQ-022 LOAD: pld_ready=1; each edge with pld_valid=1 writes pld_data into a 64x8 buffer at the write index and increments the index.
REQ-023 LOAD: after len bytes are written → HDR; pld_ready=0 in all other states.
REQ-024 Header = {len,dest}; parity accumulator = header XOR every loaded payload byte.
REQ-025 HDR: pkt_valid=1, data_out=header; advance to PLD on an edge where busy=0.
REQ-026 PLD: pkt_valid=1, data_out=buf[idx]; each edge with busy=0 increments idx; the edge that consumes the byte at idx=len-1 goes to PAR.
REQ-027 PLD never deasserts pkt_valid mid-payload, so the packet has no gaps.
REQ-028 PAR: pkt_valid=0, data_out=parity; advance to CHK on an edge where busy=0.
REQ-029 While busy=1 in HDR, PLD or PAR: state, idx, data_out and pkt_valid are held unchanged.
REQ-030 CHK lasts exactly 3 cycles with pkt_valid=0 and data_out=0x00.
REQ-031 CHK: err=1 in any CHK cycle sets err_seen; err outside CHK is ignored.
REQ-032 On leaving CHK → IDLE with done=1 for one cycle.
REQ-033 Latency, busy=0 throughout: header appears 1 cycle after the last LOAD byte; a packet occupies len+2 router cycles.

Reset
REQ-034 reset=1 immediately (asynchronously) forces IDLE, pkt_valid=0, data_out=0x00, pld_ready=0, tx_busy=0, done=0, reject=0, err_seen=0, idx=0.
REQ-035 Reset during any state aborts the packet with no further bytes driven; buffer contents are don't-care.

Configuration
REQ-036 Macro PKT_TX_PARITY_CORRUPT_EN defined: adds input corrupt_parity (1 bit), latched with an accepted start; when it is 1, the PAR byte is the bitwise inverse of the correct parity.
REQ-037 Macro undefined: the corrupt_parity port is absent and parity is always correct.

Verification
REQ-038 start dest=1 len=3, payload 0x11,0x22,0x33, busy=0 → pld_ready 3 cycles; bytes 0x0D,0x11,0x22,0x33 with pkt_valid=1; then 0x0D with pkt_valid=0; done 3 cycles later; err_seen=0.
REQ-039 Same packet with busy=1 for 4 cycles during HDR → data_out=0x0D and pkt_valid=1 held for 5 cycles, then the normal sequence.
REQ-040 start dest=3 len=5 → reject pulse; tx_busy=0 and pld_ready=0 throughout.
REQ-041 dest=2 len=63, payload 0x00..0x3E → header 0xFE, 63 gap-free payload bytes, parity 0xC1.
REQ-042 err=1 in the 2nd CHK cycle → err_seen=1 after done; err_seen cleared by the next accepted start.
REQ-043 reset asserted during the 2nd PLD byte → pkt_valid=0 and tx_busy=0 at once; a new packet then completes normally. With PKT_TX_PARITY_CORRUPT_EN and corrupt_parity=1, the REQ-038 stimulus yields parity 0xF2.
